// File: rtl/line_parser.sv
// Parses light-grid command text ("turn on/turn off/toggle r,c through r,c") into packed
// instruction beats, holding one command back so the final beat can be flagged.
//
// state   | meaning
// IDLE    | at the start of a line
// PARSE   | inside a line, bytes are being decoded
// DONE    | end of input (0x00) seen; drains the held command, then stops
module line_parser #(
    parameter int INSTRUCTION_WIDTH = 50,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inbound_valid,
    output logic                         inbound_ready,
    input  logic [7:0]                   inbound_data,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic                         instr_last,
    output logic [INSTRUCTION_WIDTH-1:0] instr_data,
    output logic                         done,
    output logic                         parse_error,
    output logic [COUNT_WIDTH-1:0]       cmd_count
);

    typedef enum logic [1:0] {S_IDLE, S_PARSE, S_DONE} state_t;

    localparam logic [1:0] OP_OFF = 2'b00;
    localparam logic [1:0] OP_TOG = 2'b01;
    localparam logic [1:0] OP_ON  = 2'b11;

    state_t            state_q, state_d;
    logic [2:0]        pos_q, pos_d;
    logic [1:0]        op_q, op_d;
    logic              op_vld_q, op_vld_d;
    logic [11:0]       acc_q, acc_d;
    logic              in_run_q, in_run_d;
    logic [2:0]        idx_q, idx_d;
    logic              bad_q, bad_d;
    logic [11:0]       sr_q, sc_q, er_q, ec_q;
    logic [11:0]       sr_d, sc_d, er_d, ec_d;
    logic [49:0]       pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [49:0]       idata_q, idata_d;
    logic              ivalid_q, ivalid_d;
    logic              ilast_q, ilast_d;
    logic              iready_q, iready_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic              accept, hs;
    logic              is_nl, is_cr, is_eoi, is_digit;
    logic [11:0]       digit_val;
    logic [2:0]        idx_c;
    logic              bad_c;
    logic [11:0]       sr_c, sc_c, er_c, ec_c;
    logic [49:0]       cmd_c;
    logic              line_ok, line_empty, new_cmd;

    assign accept    = inbound_valid && iready_q;
    assign hs        = ivalid_q && instr_ready;
    assign is_nl     = (inbound_data == 8'h0A);
    assign is_cr     = (inbound_data == 8'h0D);
    assign is_eoi    = (inbound_data == 8'h00);
    assign is_digit  = (inbound_data >= 8'h30) && (inbound_data <= 8'h39);
    assign digit_val = {8'h00, inbound_data[3:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept && !is_cr) begin
            unique case (state_q)
                S_IDLE:  if (is_eoi) state_d = S_DONE;
                         else if (!is_nl) state_d = S_PARSE;
                S_PARSE: if (is_eoi) state_d = S_DONE;
                         else if (is_nl) state_d = S_IDLE;
                default: state_d = S_DONE;
            endcase
        end
    end

    // Any non-digit byte (including the line terminator) closes an open digit run.
    always_comb begin
        idx_c = idx_q;
        bad_c = bad_q;
        sr_c  = sr_q;
        sc_c  = sc_q;
        er_c  = er_q;
        ec_c  = ec_q;
        if (in_run_q && !is_digit) begin
            if (idx_q == 3'd4) begin
                bad_c = 1'b1;
            end else begin
                idx_c = idx_q + 3'd1;
                case (idx_q)
                    3'd0:    sr_c = acc_q;
                    3'd1:    sc_c = acc_q;
                    3'd2:    er_c = acc_q;
                    default: ec_c = acc_q;
                endcase
            end
        end
        cmd_c      = {op_q, sr_c, sc_c, er_c, ec_c};
        line_ok    = op_vld_q && (idx_c == 3'd4) && !bad_c;
        line_empty = !op_vld_q && (idx_c == 3'd0) && !bad_c;
    end

    always_comb begin
        pos_d      = pos_q;
        op_d       = op_q;
        op_vld_d   = op_vld_q;
        acc_d      = acc_q;
        in_run_d   = in_run_q;
        idx_d      = idx_q;
        bad_d      = bad_q;
        sr_d       = sr_q;
        sc_d       = sc_q;
        er_d       = er_q;
        ec_d       = ec_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        idata_d    = idata_q;
        ilast_d    = ilast_q;
        ivalid_d   = ivalid_q && !hs;
        perr_d     = perr_q;
        new_cmd    = 1'b0;
        cnt_d      = hs ? cnt_q + COUNT_WIDTH'(1) : cnt_q;

        if (accept && !is_cr) begin
            if (is_nl || is_eoi) begin
                pos_d    = 3'd0;
                op_vld_d = 1'b0;
                acc_d    = 12'd0;
                in_run_d = 1'b0;
                idx_d    = 3'd0;
                bad_d    = 1'b0;
                if (line_ok) begin
                    new_cmd = 1'b1;
                end else if (!line_empty) begin
                    perr_d = 1'b1;
                end
            end else begin
                pos_d = (pos_q == 3'd7) ? 3'd7 : pos_q + 3'd1;
                if (is_digit) begin
                    acc_d    = acc_q * 12'd10 + digit_val;
                    in_run_d = 1'b1;
                end else begin
                    acc_d    = 12'd0;
                    in_run_d = 1'b0;
                    idx_d    = idx_c;
                    bad_d    = bad_c;
                    sr_d     = sr_c;
                    sc_d     = sc_c;
                    er_d     = er_c;
                    ec_d     = ec_c;
                end
                if (pos_q == 3'd1 && inbound_data == "o") begin
                    op_d     = OP_TOG;
                    op_vld_d = 1'b1;
                end else if (pos_q == 3'd6 && !op_vld_q && inbound_data == "n") begin
                    op_d     = OP_ON;
                    op_vld_d = 1'b1;
                end else if (pos_q == 3'd6 && !op_vld_q && inbound_data == "f") begin
                    op_d     = OP_OFF;
                    op_vld_d = 1'b1;
                end
            end
        end

        // A byte is only accepted while no beat is outstanding, so loading here never collides.
        if (new_cmd) begin
            if (pend_vld_q) begin
                idata_d    = pend_q;
                ilast_d    = 1'b0;
                ivalid_d   = 1'b1;
                pend_d     = cmd_c;
                pend_vld_d = 1'b1;
            end else if (is_eoi) begin
                idata_d  = cmd_c;
                ilast_d  = 1'b1;
                ivalid_d = 1'b1;
            end else begin
                pend_d     = cmd_c;
                pend_vld_d = 1'b1;
            end
        end else if (accept && is_eoi && pend_vld_q) begin
            idata_d    = pend_q;
            ilast_d    = 1'b1;
            ivalid_d   = 1'b1;
            pend_vld_d = 1'b0;
        end else if (state_q == S_DONE && pend_vld_q && (!ivalid_q || hs)) begin
            idata_d    = pend_q;
            ilast_d    = 1'b1;
            ivalid_d   = 1'b1;
            pend_vld_d = 1'b0;
        end

        done_d   = done_q || (state_d == S_DONE && !pend_vld_d && !ivalid_d);
        iready_d = (state_d != S_DONE) && !ivalid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q      <= 3'd0;
            op_q       <= OP_OFF;
            op_vld_q   <= 1'b0;
            acc_q      <= 12'd0;
            in_run_q   <= 1'b0;
            idx_q      <= 3'd0;
            bad_q      <= 1'b0;
            sr_q       <= 12'd0;
            sc_q       <= 12'd0;
            er_q       <= 12'd0;
            ec_q       <= 12'd0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            idata_q    <= '0;
            ilast_q    <= 1'b0;
            ivalid_q   <= 1'b0;
            iready_q   <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pos_q      <= pos_d;
            op_q       <= op_d;
            op_vld_q   <= op_vld_d;
            acc_q      <= acc_d;
            in_run_q   <= in_run_d;
            idx_q      <= idx_d;
            bad_q      <= bad_d;
            sr_q       <= sr_d;
            sc_q       <= sc_d;
            er_q       <= er_d;
            ec_q       <= ec_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            idata_q    <= idata_d;
            ilast_q    <= ilast_d;
            ivalid_q   <= ivalid_d;
            iready_q   <= iready_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        instr_data        = '0;
        instr_data[49:0]  = idata_q;
        instr_valid       = ivalid_q;
        instr_last        = ilast_q;
        inbound_ready     = iready_q;
        done              = done_q;
        parse_error       = perr_q;
        cmd_count         = cnt_q;
    end

endmodule

// File: tb/tb_line_parser.sv
// Directed bench for line_parser: feeds command text byte by byte and checks the
// collected beats against hand-packed instruction words.
module tb_line_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inbound_valid = 1'b0;
    logic        inbound_ready;
    logic [7:0]  inbound_data = 8'h00;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        instr_last;
    logic [49:0] instr_data;
    logic        done;
    logic        parse_error;
    logic [15:0] cmd_count;

    int n_chk  = 0;
    int n_pass = 0;

    logic [50:0] beats[$];

    line_parser #(.INSTRUCTION_WIDTH(50), .COUNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .inbound_valid(inbound_valid),
        .inbound_ready(inbound_ready),
        .inbound_data (inbound_data),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_last   (instr_last),
        .instr_data   (instr_data),
        .done         (done),
        .parse_error  (parse_error),
        .cmd_count    (cmd_count)
    );

    always #5 clk = ~clk;

    // Handshake completes on the following rising edge when both are high here.
    always @(negedge clk) begin
        #1;
        if (instr_valid && instr_ready) beats.push_back({instr_last, instr_data});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [49:0] mk(input logic [1:0] op, input int a, input int b,
                                       input int c, input int d);
        logic [11:0] a12, b12, c12, d12;
        a12 = a[11:0];
        b12 = b[11:0];
        c12 = c[11:0];
        d12 = d[11:0];
        return {op, a12, b12, c12, d12};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        inbound_valid = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        beats.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        inbound_valid = 1'b1;
        inbound_data  = b;
        while (!inbound_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
        @(negedge clk);
        inbound_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [49:0] d, input logic last);
        logic [50:0] exp;
        exp = {last, d};
        if (i < beats.size()) chk(tag, 64'(beats[i]), 64'(exp));
        else chk(tag, 64'hDEAD, 64'(exp));
    endtask

    initial begin
        int viol;
        logic [49:0] held;

        // reset values
        @(negedge clk);
        chk("rst_ready", 64'(inbound_ready), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_data",  64'(instr_data), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_perr",  64'(parse_error), 64'd0);
        chk("rst_count", 64'(cmd_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(inbound_ready), 64'd1);

        // single command
        send_str("turn on 0,0 through 999,999\n");
        chk("single_no_early_beat", 64'(beats.size()), 64'd0);
        send_byte(8'h00);
        wait_done("single_done");
        chk("single_nbeats", 64'(beats.size()), 64'd1);
        chk_beat("single_beat", 0, mk(2'b11, 0, 0, 999, 999), 1'b1);
        chk("single_count", 64'(cmd_count), 64'd1);
        chk("single_perr", 64'(parse_error), 64'd0);
        chk("single_ready_done", 64'(inbound_ready), 64'd0);

        // two commands, different opcodes
        do_reset();
        send_str("toggle 1,2 through 3,4\n");
        send_str("turn off 5,6 through 7,8\n");
        send_byte(8'h00);
        wait_done("multi_done");
        chk("multi_nbeats", 64'(beats.size()), 64'd2);
        chk_beat("multi_beat0", 0, mk(2'b01, 1, 2, 3, 4), 1'b0);
        chk_beat("multi_beat1", 1, mk(2'b00, 5, 6, 7, 8), 1'b1);
        chk("multi_count", 64'(cmd_count), 64'd2);

        // backpressure on beat 1 while the end-of-input byte waits
        do_reset();
        instr_ready = 1'b0;
        send_str("toggle 1,2 through 3,4\n");
        send_str("turn off 5,6 through 7,8\n");
        held = mk(2'b01, 1, 2, 3, 4);
        inbound_valid = 1'b1;
        inbound_data  = 8'h00;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid !== 1'b1 || instr_data !== held || inbound_ready !== 1'b0
                || instr_last !== 1'b0) viol++;
            @(negedge clk);
        end
        chk("bp_stable", 64'(viol), 64'd0);
        chk("bp_count_held", 64'(cmd_count), 64'd0);
        instr_ready = 1'b1;
        send_byte(8'h00);
        wait_done("bp_done");
        chk("bp_nbeats", 64'(beats.size()), 64'd2);
        chk_beat("bp_beat0", 0, held, 1'b0);
        chk_beat("bp_beat1", 1, mk(2'b00, 5, 6, 7, 8), 1'b1);

        // malformed middle line
        do_reset();
        send_str("turn on 1,1 through 2,2\n");
        send_str("turn on 5,5\n");
        chk("mal_perr", 64'(parse_error), 64'd1);
        send_str("toggle 3,3 through 4,4\n");
        send_byte(8'h00);
        wait_done("mal_done");
        chk("mal_nbeats", 64'(beats.size()), 64'd2);
        chk_beat("mal_beat0", 0, mk(2'b11, 1, 1, 2, 2), 1'b0);
        chk_beat("mal_beat1", 1, mk(2'b01, 3, 3, 4, 4), 1'b1);

        // empty input
        do_reset();
        send_byte(8'h00);
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_nbeats", 64'(beats.size()), 64'd0);
        chk("empty_perr", 64'(parse_error), 64'd0);

        do_reset();
        send_str("\r\n\n");
        send_byte(8'h00);
        chk("blank_done", 64'(done), 64'd1);
        chk("blank_nbeats", 64'(beats.size()), 64'd0);
        chk("blank_perr", 64'(parse_error), 64'd0);

        // 12-bit wrap, carriage return inside a line
        do_reset();
        send_str("turn off 4095,4096 through 5000,12\n");
        send_str("turn on 1,2 through 3,4\r\n");
        send_byte(8'h00);
        wait_done("wrap_done");
        chk("wrap_nbeats", 64'(beats.size()), 64'd2);
        chk_beat("wrap_beat0", 0, mk(2'b00, 4095, 0, 904, 12), 1'b0);
        chk_beat("cr_beat1", 1, mk(2'b11, 1, 2, 3, 4), 1'b1);
        chk("wrap_perr", 64'(parse_error), 64'd0);

        // reset mid-line discards pending and partial line
        do_reset();
        send_str("turn on 1,1 through 1,1\n");
        send_str("turn on 9,");
        do_reset();
        chk("midrst_count", 64'(cmd_count), 64'd0);
        send_str("toggle 10,20 through 30,40\n");
        send_byte(8'h00);
        wait_done("midrst_done");
        chk("midrst_nbeats", 64'(beats.size()), 64'd1);
        chk_beat("midrst_beat", 0, mk(2'b01, 10, 20, 30, 40), 1'b1);
        chk("midrst_count_after", 64'(cmd_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
